// File: rtl/cpu_pkg.sv
// Definitions shared by the CPU core and the memory arbiter: FSM state encoding,
// requester port indices and default memory timing.
package cpu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic P_CPU = 1'b0;
  localparam logic P_LDR = 1'b1;

  localparam int MEM_LAT_DEF = 1;
  localparam int DATA_W      = 32;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle around the memory arbiter: two requester ports plus the memory port.
// The slave modport is the arbiter's view; master is the environment's view.
interface mem_arbiter_if
  import cpu_pkg::*;
#(
  parameter int AW = 32
);

  logic              cpu_req;
  logic              cpu_we;
  logic [AW-1:0]     cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [3:0]        cpu_wmask;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_ready;

  logic              ldr_req;
  logic              ldr_we;
  logic [AW-1:0]     ldr_addr;
  logic [DATA_W-1:0] ldr_wdata;
  logic [3:0]        ldr_wmask;
  logic [DATA_W-1:0] ldr_rdata;
  logic              ldr_ready;

  logic [AW-1:0]     mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [3:0]        mem_wmask;
  logic              mem_rstrb;
  logic [DATA_W-1:0] mem_rdata;

  logic [1:0]        grant;
  logic              busy;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_wmask,
    output cpu_rdata, cpu_ready,
    input  ldr_req, ldr_we, ldr_addr, ldr_wdata, ldr_wmask,
    output ldr_rdata, ldr_ready,
    output mem_addr, mem_wdata, mem_wmask, mem_rstrb,
    input  mem_rdata,
    output grant, busy
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_wmask,
    input  cpu_rdata, cpu_ready,
    output ldr_req, ldr_we, ldr_addr, ldr_wdata, ldr_wmask,
    input  ldr_rdata, ldr_ready,
    input  mem_addr, mem_wdata, mem_wmask, mem_rstrb,
    output mem_rdata,
    input  grant, busy
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: a lone requester always wins; on a tie the port
// that did not win last time is chosen. Purely combinational, one-hot result.
module rr_arb2
  import cpu_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last_grant == P_LDR) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single progmem port between the CPU and the loader. Each access
// runs IDLE -> ISSUE -> (WAIT) -> DONE with exactly one transaction in flight.
module mem_arbiter
  import cpu_pkg::*;
#(
  parameter int MEM_LAT = MEM_LAT_DEF,
  parameter int AW      = 32
)(
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  localparam logic [2:0] LAT_M1 = 3'(MEM_LAT - 1);

  state_t            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              take;
  logic [1:0]        gnt;
  logic              pick_ldr;

  logic              owner_q;
  logic              last_grant_q;
  logic [1:0]        grant_q;
  logic              we_q;
  logic [AW-1:0]     addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [3:0]        wmask_q;
  logic [DATA_W-1:0] cpu_rdata_q, ldr_rdata_q;

  logic              cpu_ready_c, ldr_ready_c;
  logic [DATA_W-1:0] done_data;

  rr_arb2 u_rr (
    .req        ({bus.ldr_req, bus.cpu_req}),
    .last_grant (last_grant_q),
    .gnt        (gnt)
  );

  assign pick_ldr = gnt[1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    take    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|gnt) begin
          take    = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = LAT_M1;
        state_d = (MEM_LAT == 1) ? ST_DONE : ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt_q == 3'd1) state_d = ST_DONE;
        else               cnt_d   = cnt_q - 3'd1;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Strobes and ready are decoded from registered state so an asynchronous
  // reset removes them at once, without waiting for a clock edge.
  assign cpu_ready_c = (state_q == ST_DONE) && (owner_q == P_CPU);
  assign ldr_ready_c = (state_q == ST_DONE) && (owner_q == P_LDR);
  assign done_data   = we_q ? '0 : bus.mem_rdata;

  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.grant     = grant_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_rstrb = (state_q == ST_ISSUE) && !we_q;
  assign bus.mem_wmask = ((state_q == ST_ISSUE) && we_q) ? wmask_q : 4'b0000;
  assign bus.cpu_ready = cpu_ready_c;
  assign bus.ldr_ready = ldr_ready_c;
  // Read data passes straight through during DONE and is held afterwards.
  assign bus.cpu_rdata = cpu_ready_c ? done_data : cpu_rdata_q;
  assign bus.ldr_rdata = ldr_ready_c ? done_data : ldr_rdata_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 3'd0;
      owner_q      <= P_CPU;
      last_grant_q <= P_LDR;
      grant_q      <= 2'b00;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wmask_q      <= 4'b0000;
      cpu_rdata_q  <= '0;
      ldr_rdata_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (take) begin
        owner_q      <= pick_ldr;
        last_grant_q <= pick_ldr;
        grant_q      <= gnt;
        we_q         <= pick_ldr ? bus.ldr_we    : bus.cpu_we;
        addr_q       <= pick_ldr ? bus.ldr_addr  : bus.cpu_addr;
        wdata_q      <= pick_ldr ? bus.ldr_wdata : bus.cpu_wdata;
        wmask_q      <= pick_ldr ? bus.ldr_wmask : bus.cpu_wmask;
      end else if (state_q == ST_DONE) begin
        grant_q <= 2'b00;
      end
      if (cpu_ready_c) cpu_rdata_q <= done_data;
      if (ldr_ready_c) ldr_rdata_q <= done_data;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter at MEM_LAT = 1, 2 and 3 with hand-computed
// expectations for each cycle of every transaction.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;
  int   strobes;
  logic [1:0] exp_g;
  logic       exp_cr, exp_lr;

  always #5 clk = ~clk;

  mem_arbiter_if #(.AW(32)) b1 ();
  mem_arbiter_if #(.AW(32)) b2 ();
  mem_arbiter_if #(.AW(32)) b3 ();

  mem_arbiter #(.MEM_LAT(1), .AW(32)) u1 (.clk(clk), .rst(rst), .bus(b1));
  mem_arbiter #(.MEM_LAT(2), .AW(32)) u2 (.clk(clk), .rst(rst), .bus(b2));
  mem_arbiter #(.MEM_LAT(3), .AW(32)) u3 (.clk(clk), .rst(rst), .bus(b3));

  function automatic logic [31:0] lookup(input logic [31:0] a);
    return (a == 32'h8) ? 32'h00A00093 : {a[15:0], 16'hC0DE};
  endfunction

  // One-cycle-latency synchronous memory for u1
  always @(posedge clk) if (b1.mem_rstrb) b1.mem_rdata <= lookup(b1.mem_addr);
  // u2/u3 memories are address-decoded; their address is stable until DONE
  assign b2.mem_rdata = {b2.mem_addr[15:0], 16'h5A5A};
  assign b3.mem_rdata = {b3.mem_addr[15:0], 16'h5A5A};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    b1.cpu_req = 0; b1.cpu_we = 0; b1.cpu_addr = 0; b1.cpu_wdata = 0; b1.cpu_wmask = 0;
    b1.ldr_req = 0; b1.ldr_we = 0; b1.ldr_addr = 0; b1.ldr_wdata = 0; b1.ldr_wmask = 0;
    b1.mem_rdata = 0;
    b2.cpu_req = 0; b2.cpu_we = 0; b2.cpu_addr = 0; b2.cpu_wdata = 0; b2.cpu_wmask = 0;
    b2.ldr_req = 0; b2.ldr_we = 0; b2.ldr_addr = 0; b2.ldr_wdata = 0; b2.ldr_wmask = 0;
    b3.cpu_req = 0; b3.cpu_we = 0; b3.cpu_addr = 0; b3.cpu_wdata = 0; b3.cpu_wmask = 0;
    b3.ldr_req = 0; b3.ldr_we = 0; b3.ldr_addr = 0; b3.ldr_wdata = 0; b3.ldr_wmask = 0;

    step(); step();
    chk("rst_busy",  b1.busy, 0);
    chk("rst_grant", b1.grant, 0);
    chk("rst_crdy",  b1.cpu_ready, 0);
    chk("rst_lrdy",  b1.ldr_ready, 0);
    chk("rst_maddr", b1.mem_addr, 0);
    chk("rst_wmask", b1.mem_wmask, 0);
    chk("rst_rstrb", b1.mem_rstrb, 0);
    chk("rst_crdat", b1.cpu_rdata, 0);
    rst = 1'b1;

    // Both ports on u2 request continuously from the first cycle out of reset
    step();
    b2.cpu_req = 1; b2.cpu_addr = 32'h40;
    b2.ldr_req = 1; b2.ldr_addr = 32'h44;
    for (int c = 0; c < 18; c++) begin
      if (c < 16 && (c % 4) != 0) exp_g = ((c / 4) % 2 == 0) ? 2'b01 : 2'b10;
      else                        exp_g = 2'b00;
      exp_cr = (c < 16) && (c % 4 == 3) && ((c / 4) % 2 == 0);
      exp_lr = (c < 16) && (c % 4 == 3) && ((c / 4) % 2 == 1);
      chk($sformatf("rr_grant_c%0d", c), b2.grant, exp_g);
      chk($sformatf("rr_crdy_c%0d", c), b2.cpu_ready, exp_cr);
      chk($sformatf("rr_lrdy_c%0d", c), b2.ldr_ready, exp_lr);
      chk($sformatf("rr_busy_c%0d", c), b2.busy, exp_g != 2'b00);
      if (c == 3) chk("rr_crdat", b2.cpu_rdata, 32'h00405A5A);
      if (c == 7) chk("rr_lrdat", b2.ldr_rdata, 32'h00445A5A);
      if (c == 8) chk("rr_crdat_hold", b2.cpu_rdata, 32'h00405A5A);
      if (c == 16) begin b2.cpu_req = 0; b2.ldr_req = 0; end
      step();
    end

    // u3 (MEM_LAT=3): CPU drops its request during WAIT
    b3.cpu_req = 1; b3.cpu_addr = 32'h50;
    strobes = 0;
    for (int c = 0; c < 7; c++) begin
      if (b3.mem_rstrb) strobes++;
      chk($sformatf("drop_rstrb_c%0d", c), b3.mem_rstrb, c == 1);
      chk($sformatf("drop_crdy_c%0d", c), b3.cpu_ready, c == 4);
      chk($sformatf("drop_busy_c%0d", c), b3.busy, c >= 1 && c <= 4);
      if (c == 4) chk("drop_crdat", b3.cpu_rdata, 32'h00505A5A);
      if (c == 2) b3.cpu_req = 0;
      step();
    end
    chk("drop_strobes", strobes, 1);

    // u1: single CPU read of address 0x8
    b1.cpu_req = 1; b1.cpu_we = 0; b1.cpu_addr = 32'h8;
    chk("rd_c0_busy", b1.busy, 0);
    step();
    chk("rd_c1_rstrb", b1.mem_rstrb, 1);
    chk("rd_c1_addr",  b1.mem_addr, 32'h8);
    chk("rd_c1_wmask", b1.mem_wmask, 0);
    chk("rd_c1_grant", b1.grant, 2'b01);
    chk("rd_c1_crdy",  b1.cpu_ready, 0);
    step();
    chk("rd_c2_crdy",  b1.cpu_ready, 1);
    chk("rd_c2_crdat", b1.cpu_rdata, 32'h00A00093);
    chk("rd_c2_lrdy",  b1.ldr_ready, 0);
    chk("rd_c2_rstrb", b1.mem_rstrb, 0);
    b1.cpu_req = 0;
    step();
    chk("rd_c3_crdy",  b1.cpu_ready, 0);
    chk("rd_c3_hold",  b1.cpu_rdata, 32'h00A00093);
    chk("rd_c3_busy",  b1.busy, 0);
    chk("rd_c3_grant", b1.grant, 0);
    chk("rd_c3_addr",  b1.mem_addr, 32'h8);

    // u1: loader write with partial byte mask
    b1.ldr_req = 1; b1.ldr_we = 1; b1.ldr_addr = 32'h10;
    b1.ldr_wdata = 32'hDEADBEEF; b1.ldr_wmask = 4'b0011;
    step();
    chk("wr_c1_wmask", b1.mem_wmask, 4'b0011);
    chk("wr_c1_rstrb", b1.mem_rstrb, 0);
    chk("wr_c1_wdata", b1.mem_wdata, 32'hDEADBEEF);
    chk("wr_c1_addr",  b1.mem_addr, 32'h10);
    chk("wr_c1_grant", b1.grant, 2'b10);
    step();
    chk("wr_c2_wmask", b1.mem_wmask, 0);
    chk("wr_c2_lrdy",  b1.ldr_ready, 1);
    chk("wr_c2_lrdat", b1.ldr_rdata, 0);
    chk("wr_c2_crdy",  b1.cpu_ready, 0);
    b1.ldr_req = 0;
    step();
    chk("wr_c3_lrdy", b1.ldr_ready, 0);
    chk("wr_c3_busy", b1.busy, 0);

    // u1: CPU write with empty mask still completes
    b1.cpu_req = 1; b1.cpu_we = 1; b1.cpu_addr = 32'h20;
    b1.cpu_wdata = 32'h55AA55AA; b1.cpu_wmask = 4'b0000;
    step();
    chk("wz_c1_wmask", b1.mem_wmask, 0);
    chk("wz_c1_rstrb", b1.mem_rstrb, 0);
    chk("wz_c1_busy",  b1.busy, 1);
    step();
    chk("wz_c2_crdy",  b1.cpu_ready, 1);
    chk("wz_c2_crdat", b1.cpu_rdata, 0);
    b1.cpu_req = 0;
    step();

    // u1: asynchronous reset in the middle of a write ISSUE
    b1.cpu_req = 1; b1.cpu_we = 1; b1.cpu_addr = 32'h30;
    b1.cpu_wdata = 32'h11223344; b1.cpu_wmask = 4'hF;
    step();
    chk("ar_pre_wmask", b1.mem_wmask, 4'hF);
    #2 rst = 1'b0;
    #1;
    chk("ar_wmask", b1.mem_wmask, 0);
    chk("ar_busy",  b1.busy, 0);
    chk("ar_grant", b1.grant, 0);
    chk("ar_crdy",  b1.cpu_ready, 0);
    b1.cpu_req = 0;
    step(); step();
    rst = 1'b1;
    b1.cpu_req = 1; b1.cpu_we = 0; b1.cpu_addr = 32'h8;
    b1.ldr_req = 1; b1.ldr_we = 0; b1.ldr_addr = 32'h10;
    step();
    chk("ar_tie_grant", b1.grant, 2'b01);
    chk("ar_tie_rstrb", b1.mem_rstrb, 1);
    chk("ar_tie_addr",  b1.mem_addr, 32'h8);
    step();
    chk("ar_tie_crdy",  b1.cpu_ready, 1);
    chk("ar_tie_lrdy",  b1.ldr_ready, 0);
    chk("ar_tie_crdat", b1.cpu_rdata, 32'h00A00093);
    b1.cpu_req = 0;
    step();
    chk("ar_idle_busy", b1.busy, 0);
    step();
    chk("ar_ldr_grant", b1.grant, 2'b10);
    chk("ar_ldr_addr",  b1.mem_addr, 32'h10);
    step();
    chk("ar_ldr_lrdy",  b1.ldr_ready, 1);
    chk("ar_ldr_lrdat", b1.ldr_rdata, 32'h0010C0DE);
    b1.ldr_req = 0;
    step();
    chk("ar_end_busy", b1.busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single program/data memory port between two requesters: the CPU (port 0) and the program loader/debug port (port 1).
- Sequences each access as issue, latency wait, then completion, so that the memory strobes and the capture timing are owned here rather than by the CPU state machine.
- Sits between the CPU core and the progmem RAM.
- Round-robin arbitration; exactly one transaction is outstanding at a time.

Parameters:
- MEM_LAT, 1, memory read latency in cycles from the strobe to valid mem_rdata (legal range 1..7).
- AW, 32, address width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous assert, active-low (0 = reset).
- cpu_req  in  1  CPU access request; held high until cpu_ready.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  AW  byte address.
- cpu_wdata  in  32  write data.
- cpu_wmask  in  4  byte enables for a write.
- cpu_rdata  out  32  read data, valid while cpu_ready = 1.
- cpu_ready  out  1  one-cycle completion pulse.
- ldr_req, ldr_we, ldr_addr, ldr_wdata, ldr_wmask, ldr_rdata, ldr_ready  same as the cpu_* ports, for the loader.
- mem_addr  out  AW  address to memory.
- mem_wdata  out  32  write data to memory.
- mem_wmask  out  4  byte write strobes; nonzero for one cycle only.
- mem_rstrb  out  1  read strobe; one cycle.
- mem_rdata  in  32  memory read data.
- grant  out  2  one-hot current owner (bit0 = cpu, bit1 = ldr); 0 when idle.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values: all outputs 0; state IDLE; last_grant = ldr, so the CPU wins the first tie.
- Reset is asynchronous. Asserting it mid-transaction aborts the transaction with no ready pulse, and mem_wmask / mem_rstrb drop in the same cycle.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If any req is high, pick the owner. With both high, choose the requester that is not last_grant.
  - Latch owner, we, addr, wdata and wmask into internal registers.
  - Set grant and last_grant, then go to ISSUE.
  - With no req, stay in IDLE.
- ISSUE (exactly 1 cycle):
  - mem_addr = latched addr.
  - For a read: mem_rstrb = 1, mem_wmask = 0.
  - For a write: mem_wmask = latched wmask, mem_wdata = latched wdata, mem_rstrb = 0.
  - Load the latency counter with MEM_LAT-1. If MEM_LAT = 1, go directly to DONE; otherwise go to WAIT.
- WAIT:
  - Counter decrements each cycle; at 1, go to DONE.
  - mem_addr stays stable; the strobes are 0.
- DONE (exactly 1 cycle):
  - Owner's ready = 1.
  - Owner's rdata = mem_rdata captured in the registered output (a read sampled at the end of WAIT/ISSUE + MEM_LAT). A write returns rdata = 0.
  - Next state is IDLE; grant clears.
- Latency:
  - req sampled in IDLE at cycle t, strobe at t+1, ready at t+1+MEM_LAT.
  - Back-to-back throughput is one access per MEM_LAT+2 cycles.
- Requests are sampled only in IDLE. Changes to the other port's req, or to the owner's addr/data mid-transaction, are ignored because everything is latched.
- If the owner drops req before DONE, the transaction still completes, the memory access still occurs, and ready still pulses.
- A write with wmask = 4'b0000 issues no strobe but still completes with a ready pulse.
- The ready of the non-owner is always 0; the two ready outputs are never high in the same cycle.
- rdata outputs hold their last value outside DONE; only the ready pulse qualifies them.
- mem_addr holds the last issued address while idle, so no glitching toward the memory.
- Starvation bound: with both ports continuously requesting, strict alternation gives each port a grant at least every 2·(MEM_LAT+2) cycles.

Decomposition:
- Shared package (cpu_pkg), reused by the CPU FSM:
  - State encodings ST_IDLE=0, ST_ISSUE=1, ST_WAIT=2, ST_DONE=3.
  - Port indices P_CPU=0, P_LDR=1.
  - MEM_LAT default.
- One natural sub-module, rr_arb2: combinational 2-way round-robin pick from (req[1:0], last_grant), returning a one-hot grant. Everything else lives in mem_arbiter.

Test Plan:
- Single CPU read, MEM_LAT=1, mem returns 0x00A00093 for addr 0x8:
  - cpu_req rises at cycle 0.
  - mem_rstrb = 1 at cycle 1 with mem_addr = 0x8.
  - cpu_ready = 1 at cycle 2 with cpu_rdata = 0x00A00093.
  - ldr_ready stays 0.
- Loader write addr 0x10, wdata 0xDEADBEEF, wmask 4'b0011:
  - mem_wmask = 0011 for exactly one cycle, mem_rstrb = 0.
  - ldr_ready pulses 2 cycles after the request, ldr_rdata = 0.
- Both requesting continuously out of reset, MEM_LAT=2:
  - grant sequence is cpu, ldr, cpu, ldr.
  - ready pulses at cycles 3, 7, 11, 15, alternating ports.
- CPU drops cpu_req in WAIT (MEM_LAT=3):
  - the access still strobes once and cpu_ready still pulses at cycle 4.
  - the next IDLE with no request stays idle, busy = 0.
- rst driven low mid-ISSUE of a write:
  - mem_wmask, busy, grant and ready go to 0 immediately, without waiting for a clock edge.
  - after release, the first tie is granted to the CPU.
- Write with wmask = 0:
  - no strobe is issued.
  - ready still pulses at t+1+MEM_LAT.
